// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the core load/store unit:
// funct3 size codes, the request record and the access legality rule.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

    // Unsigned sizes exist only for loads; halfwords need 2-byte and words 4-byte alignment.
    function automatic logic dmem_access_legal(input logic       we,
                                               input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = ~we;
            F3_H:    ok = ~addr_lo[0];
            F3_HU:   ok = ~we & ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_align_check.sv
// Combinational legality check of one access (size code versus store/load and
// address alignment).
module dmem_align_check
    import dmem_pkg::*;
(
    input  logic       we,
    input  logic [2:0] funct3,
    input  logic [1:0] addr,
    output logic       legal
);

    always_comb begin
        legal = dmem_access_legal(we, funct3, addr);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the load/store unit (port 0) and the DMA engine
// (port 1) in front of the single-port data memory, with a bounded port-1 lock.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_funct3,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_funct3,
    input  logic        p1_lock,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        p0_err,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_MemW,
    output logic        mem_memRead,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    port_e       prio_q, prio_d;
    port_e       owner_q, owner_d;
    port_e       resp_port_q, resp_port_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic        p0_err_q, p0_err_d, p1_err_q, p1_err_d;

    logic        gnt0, gnt1, any_gnt, lock_hold, legal;
    logic [31:0] resp_rdata;
    dmem_req_t   win;

    // Grants are forced low during reset so the memory never sees a strobe then.
    always_comb begin
        lock_hold = (owner_q == PORT1) && p1_lock && p1_req && (lock_cnt_q < LOCK_LIMIT);
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (lock_hold) begin
                gnt1 = 1'b1;
            end else if (p0_req && p1_req) begin
                gnt0 = (prio_q == PORT0);
                gnt1 = (prio_q == PORT1);
            end else begin
                gnt0 = p0_req;
                gnt1 = p1_req;
            end
        end
        any_gnt = gnt0 | gnt1;
        if (gnt1) begin
            win = dmem_req_t'{we: p1_we, addr: p1_addr, wdata: p1_wdata, funct3: p1_funct3};
        end else begin
            win = dmem_req_t'{we: p0_we, addr: p0_addr, wdata: p0_wdata, funct3: p0_funct3};
        end
    end

    dmem_align_check u_align (
        .we     (win.we),
        .funct3 (win.funct3),
        .addr   (win.addr[1:0]),
        .legal  (legal)
    );

    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_funct3  = '0;
        mem_MemW    = 1'b0;
        mem_memRead = 1'b0;
        if (any_gnt) begin
            mem_addr    = win.addr;
            mem_wdata   = win.wdata;
            mem_funct3  = win.funct3;
            mem_MemW    = legal & win.we;
            mem_memRead = legal & ~win.we;
        end
    end

    always_comb begin
        prio_d       = prio_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        resp_valid_d = any_gnt;
        resp_port_d  = gnt1 ? PORT1 : PORT0;
        resp_rdata   = (legal && !win.we) ? mem_rdata : '0;
        p0_rdata_d   = gnt0 ? resp_rdata : p0_rdata_q;
        p0_err_d     = gnt0 ? ~legal : p0_err_q;
        p1_rdata_d   = gnt1 ? resp_rdata : p1_rdata_q;
        p1_err_d     = gnt1 ? ~legal : p1_err_q;

        if (any_gnt) begin
            owner_d = gnt1 ? PORT1 : PORT0;
            prio_d  = gnt1 ? PORT0 : PORT1;
        end

        // Counts only port-1 grants that actually make port 0 wait.
        if (gnt0 || !p0_req) begin
            lock_cnt_d = '0;
        end else if (gnt1 && (lock_cnt_q < LOCK_LIMIT)) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q       <= PORT0;
            owner_q      <= PORT0;
            resp_port_q  <= PORT0;
            lock_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            p0_err_q     <= 1'b0;
            p1_err_q     <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            resp_port_q  <= resp_port_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_valid_q <= resp_valid_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            p0_err_q     <= p0_err_d;
            p1_err_q     <= p1_err_d;
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = resp_valid_q && (resp_port_q == PORT0);
    assign p1_rvalid = resp_valid_q && (resp_port_q == PORT1);
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural byte memory behind the mem_* port and a
// response scoreboard filled at grant time and drained on rvalid.
module tb_dmem_arbiter;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
        bit          err;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [2:0]  p0_funct3, p1_funct3;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_MemW, mem_memRead;
    logic [2:0]  mem_funct3;

    int vectors = 0;
    int miscompares = 0;
    resp_t sb[$];

    dmem_arbiter #(.LOCK_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_funct3   (p0_funct3),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_funct3   (p1_funct3),
        .p1_lock     (p1_lock),
        .p0_gnt      (p0_gnt),
        .p1_gnt      (p1_gnt),
        .p0_rvalid   (p0_rvalid),
        .p1_rvalid   (p1_rvalid),
        .p0_rdata    (p0_rdata),
        .p1_rdata    (p1_rdata),
        .p0_err      (p0_err),
        .p1_err      (p1_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_MemW    (mem_MemW),
        .mem_memRead (mem_memRead),
        .mem_funct3  (mem_funct3),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational sign/zero-extending read, write on the edge.
    logic [7:0] mem [0:1023];
    logic [9:0] ma;

    always_comb begin
        ma = mem_addr[9:0];
        mem_rdata = '0;
        if (mem_memRead) begin
            case (mem_funct3)
                3'b000:  mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
                3'b100:  mem_rdata = {24'h0, mem[ma]};
                3'b001:  mem_rdata = {{16{mem[ma+10'd1][7]}}, mem[ma+10'd1], mem[ma]};
                3'b101:  mem_rdata = {16'h0, mem[ma+10'd1], mem[ma]};
                3'b010:  mem_rdata = {mem[ma+10'd3], mem[ma+10'd2], mem[ma+10'd1], mem[ma]};
                default: mem_rdata = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_MemW) begin
            case (mem_funct3)
                3'b000: mem[ma] <= mem_wdata[7:0];
                3'b001: begin
                    mem[ma]       <= mem_wdata[7:0];
                    mem[ma+10'd1] <= mem_wdata[15:8];
                end
                3'b010: begin
                    mem[ma]       <= mem_wdata[7:0];
                    mem[ma+10'd1] <= mem_wdata[15:8];
                    mem[ma+10'd2] <= mem_wdata[23:16];
                    mem[ma+10'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // Response monitor: every rvalid must match the oldest pending expectation.
    always @(negedge clk) begin
        resp_t       e;
        logic [31:0] act_rdata;
        logic        act_err;
        if (p0_rvalid || p1_rvalid) begin
            vectors++;
            act_rdata = p1_rvalid ? p1_rdata : p0_rdata;
            act_err   = p1_rvalid ? p1_err : p0_err;
            if (p0_rvalid && p1_rvalid) begin
                miscompares++;
                $display("FAIL resp_both: p0_rvalid=1 p1_rvalid=1, required only one");
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected: port %0d rvalid rdata=%h err=%b, required none", p1_rvalid, act_rdata, act_err);
            end else begin
                e = sb.pop_front();
                if (p1_rvalid !== e.port || act_rdata !== e.rdata || act_err !== e.err) begin
                    miscompares++;
                    $display("FAIL resp: port=%0d rdata=%h err=%b, required port=%0d rdata=%h err=%b",
                             p1_rvalid, act_rdata, act_err, e.port, e.rdata, e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_funct3 = f3;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3, input logic lock);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_funct3 = f3; p1_lock = lock;
    endtask

    task automatic idle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    endtask

    task automatic expect_resp(input bit port, input logic [31:0] rdata, input logic err);
        resp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err} !== 6'b0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: ctl=%b p0_rdata=%h p1_rdata=%h, required all 0",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err}, p0_rdata, p1_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({mem_MemW, mem_memRead, p0_gnt, p1_gnt} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_funct3 !== 3'b0) begin
            miscompares++;
            $display("FAIL idle_mem: strobes/gnt=%b addr=%h wdata=%h f3=%b, required all 0",
                     {mem_MemW, mem_memRead, p0_gnt, p1_gnt}, mem_addr, mem_wdata, mem_funct3);
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        drive1(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt, mem_MemW, mem_memRead} !== 4'b1010 || mem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL single_store: gnt/strobes=%b addr=%h, required 1010 addr=00000010",
                     {p1_gnt, p0_gnt, mem_MemW, mem_memRead}, mem_addr);
        end
        expect_resp(1'b1, 32'h0, 1'b0);
        @(negedge clk);
        idle();
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt, mem_MemW, mem_memRead} !== 4'b0101) begin
            miscompares++;
            $display("FAIL single_load: gnt/strobes=%b, required 0101", {p1_gnt, p0_gnt, mem_MemW, mem_memRead});
        end
        expect_resp(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL single_pending: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive0(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
            drive1(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
            #1;
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if ({p1_gnt, p0_gnt} !== g) begin
                miscompares++;
                $display("FAIL rr_cycle%0d: gnt={p1,p0}=%b, required %b", i, {p1_gnt, p0_gnt}, g);
            end
            expect_resp(g[1], 32'hDEADBEEF, 1'b0);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rr_pending: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_lock();
        logic [1:0] g;
        apply_reset();
        @(negedge clk);
        drive1(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL lock_prime: gnt=%b, required 10", {p1_gnt, p0_gnt});
        end
        expect_resp(1'b1, 32'hDEADBEEF, 1'b0);
        // Four locked port-1 grants, one forced port-0 grant, repeating.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive0(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
            #1;
            g = (i % 5 == 4) ? 2'b01 : 2'b10;
            vectors++;
            if ({p1_gnt, p0_gnt} !== g) begin
                miscompares++;
                $display("FAIL lock_starve%0d: gnt=%b, required %b", i, {p1_gnt, p0_gnt}, g);
            end
            expect_resp(g[1], 32'hDEADBEEF, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
            #1;
            vectors++;
            if ({p1_gnt, p0_gnt} !== 2'b10) begin
                miscompares++;
                $display("FAIL lock_hold%0d: gnt=%b, required 10", i, {p1_gnt, p0_gnt});
            end
            expect_resp(1'b1, 32'hDEADBEEF, 1'b0);
        end
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        drive1(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt} !== 2'b01) begin
            miscompares++;
            $display("FAIL lock_release: gnt=%b, required 01", {p1_gnt, p0_gnt});
        end
        expect_resp(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL lock_release_next: gnt=%b, required 10", {p1_gnt, p0_gnt});
        end
        expect_resp(1'b1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL lock_pending: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_misaligned();
        acc_t t[$];
        logic [1:0] g, s;
        t.push_back('{1'b1, 1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0,        1'b0});
        t.push_back('{1'b0, 1'b0, 32'h13, 32'h0,        3'b010, 32'h0,        1'b1});
        t.push_back('{1'b1, 1'b1, 32'h21, 32'h0000AAAA, 3'b001, 32'h0,        1'b1});
        t.push_back('{1'b0, 1'b0, 32'h20, 32'h0,        3'b010, 32'h11223344, 1'b0});
        t.push_back('{1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 3'b100, 32'h0,        1'b1});
        t.push_back('{1'b0, 1'b0, 32'h22, 32'h0,        3'b001, 32'h00001122, 1'b0});
        t.push_back('{1'b0, 1'b0, 32'h23, 32'h0,        3'b101, 32'h0,        1'b1});
        t.push_back('{1'b1, 1'b0, 32'h20, 32'h0,        3'b011, 32'h0,        1'b1});
        t.push_back('{1'b0, 1'b0, 32'h20, 32'h0,        3'b010, 32'h11223344, 1'b0});
        foreach (t[i]) begin
            @(negedge clk);
            idle();
            if (t[i].port) drive1(1'b1, t[i].we, t[i].addr, t[i].wdata, t[i].f3, 1'b0);
            else           drive0(1'b1, t[i].we, t[i].addr, t[i].wdata, t[i].f3);
            #1;
            g = t[i].port ? 2'b10 : 2'b01;
            s = {~t[i].err & t[i].we, ~t[i].err & ~t[i].we};
            vectors++;
            if ({p1_gnt, p0_gnt} !== g || {mem_MemW, mem_memRead} !== s) begin
                miscompares++;
                $display("FAIL misalign%0d: gnt=%b strobes=%b, required gnt=%b strobes=%b",
                         i, {p1_gnt, p0_gnt}, {mem_MemW, mem_memRead}, g, s);
            end
            expect_resp(t[i].port, t[i].rdata, t[i].err);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL misalign_pending: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_subword();
        acc_t t[$];
        logic [1:0] g, s;
        t.push_back('{1'b1, 1'b1, 32'h40, 32'h80FF7F01, 3'b010, 32'h0,        1'b0});
        t.push_back('{1'b0, 1'b0, 32'h41, 32'h0,        3'b000, 32'h0000007F, 1'b0});
        t.push_back('{1'b0, 1'b0, 32'h42, 32'h0,        3'b100, 32'h000000FF, 1'b0});
        t.push_back('{1'b0, 1'b0, 32'h42, 32'h0,        3'b001, 32'hFFFF80FF, 1'b0});
        t.push_back('{1'b0, 1'b0, 32'h42, 32'h0,        3'b101, 32'h000080FF, 1'b0});
        t.push_back('{1'b0, 1'b0, 32'h43, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
        t.push_back('{1'b1, 1'b1, 32'h40, 32'hAAAAAA55, 3'b000, 32'h0,        1'b0});
        t.push_back('{1'b0, 1'b0, 32'h40, 32'h0,        3'b010, 32'h80FF7F55, 1'b0});
        t.push_back('{1'b1, 1'b1, 32'h42, 32'h1234BEEF, 3'b001, 32'h0,        1'b0});
        t.push_back('{1'b0, 1'b0, 32'h40, 32'h0,        3'b010, 32'hBEEF7F55, 1'b0});
        foreach (t[i]) begin
            @(negedge clk);
            idle();
            if (t[i].port) drive1(1'b1, t[i].we, t[i].addr, t[i].wdata, t[i].f3, 1'b0);
            else           drive0(1'b1, t[i].we, t[i].addr, t[i].wdata, t[i].f3);
            #1;
            g = t[i].port ? 2'b10 : 2'b01;
            s = {t[i].we, ~t[i].we};
            vectors++;
            if ({p1_gnt, p0_gnt} !== g || {mem_MemW, mem_memRead} !== s || mem_funct3 !== t[i].f3) begin
                miscompares++;
                $display("FAIL subword%0d: gnt=%b strobes=%b f3=%b, required gnt=%b strobes=%b f3=%b",
                         i, {p1_gnt, p0_gnt}, {mem_MemW, mem_memRead}, mem_funct3, g, s, t[i].f3);
            end
            expect_resp(t[i].port, t[i].rdata, t[i].err);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL subword_pending: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        idle();
        drive0(1'b1, 1'b1, 32'h50, 32'hCAFEF00D, 3'b010);
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt, mem_MemW} !== 3'b011) begin
            miscompares++;
            $display("FAIL rst_setup_store: gnt/MemW=%b, required 011", {p1_gnt, p0_gnt, mem_MemW});
        end
        expect_resp(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        #1;
        expect_resp(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive1(1'b1, 1'b1, 32'h50, 32'h12345678, 3'b010, 1'b0);
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt, mem_MemW, p0_rvalid} !== 4'b1011 || p0_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rst_pre: gnt/MemW/p0_rvalid=%b p0_rdata=%h, required 1011 DEADBEEF",
                     {p1_gnt, p0_gnt, mem_MemW, p0_rvalid}, p0_rdata);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt, mem_MemW, mem_memRead, p0_rvalid, p1_rvalid} !== 6'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || p0_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid: ctl=%b addr=%h wdata=%h p0_rdata=%h, required all 0",
                     {p1_gnt, p0_gnt, mem_MemW, mem_memRead, p0_rvalid, p1_rvalid}, mem_addr, mem_wdata, p0_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b1, 1'b0, 32'h50, 32'h0, 3'b010);
        drive1(1'b1, 1'b0, 32'h50, 32'h0, 3'b010, 1'b0);
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt} !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_prio: gnt=%b, required 01", {p1_gnt, p0_gnt});
        end
        expect_resp(1'b0, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        #1;
        vectors++;
        if ({p1_gnt, p0_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_prio_next: gnt=%b, required 10", {p1_gnt, p0_gnt});
        end
        expect_resp(1'b1, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rst_pending: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_misaligned();
        test_subword();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
